slice_swap_fifo: RTL
====================

SLICE_SWAP_FIFO -- requirements
Module: slice_swap_fifo

Interface
- REQ-001: Parameter DEPTH, default 4 -- number of 16-bit entries; SHALL be a power of two, 2..16.
- REQ-002: Parameter SWAP, default 1 -- 1 = store byte-swapped word {in_data[7:0], in_data[15:8]}; 0 = store word unchanged.
- REQ-003: CLK  input  1 -- sole clock; all state updates on rising edge.
- REQ-004: RESET  input  1 -- synchronous, active-high reset.
- REQ-005: in_data  input  16 -- upstream word.
- REQ-006: in_valid  input  1 -- upstream word valid.
- REQ-007: in_ready  output  1 -- block can accept a word this cycle.
- REQ-008: out_data  output  16 -- head-of-queue word, stored form.
- REQ-009: out_valid  output  1 -- out_data valid.
- REQ-010: out_ready  input  1 -- downstream consumes the head this cycle.
- REQ-011: count  output  $clog2(DEPTH)+1 -- current occupancy, 0..DEPTH.

Function
- REQ-012: Push SHALL occur on an edge where in_valid=1 and in_ready=1; the stored word is the SWAP-selected form of in_data.
- REQ-013: Pop SHALL occur on an edge where out_valid=1 and out_ready=1; the head entry is removed.
- REQ-014: in_ready SHALL equal (count < DEPTH), decoded combinationally from registered count only; no dependence on out_ready.
- REQ-015: out_valid SHALL equal (count != 0); out_data SHALL show the head entry when out_valid=1, and 16'h0000 when out_valid=0.
- REQ-016: Latency: a word pushed at edge N SHALL be visible on out_data/out_valid after edge N (cycle N+1) when the queue was empty; no same-cycle input-to-output bypass.
- REQ-017: Order SHALL be strict FIFO; no word dropped, duplicated or reordered.
- REQ-018: Write and read pointers SHALL be log2(DEPTH) bits and wrap from DEPTH-1 to 0.
- REQ-019: Simultaneous push and pop with 0 < count < DEPTH: both occur, count unchanged.
- REQ-020: Full (count=DEPTH): in_ready=0, so no push even if out_ready=1 on the same edge; the pop proceeds and count becomes DEPTH-1.
- REQ-021: Empty (count=0): out_valid=0, so no pop; a push proceeds and count becomes 1.
- REQ-022: in_data SHALL be ignored when in_valid=0 or in_ready=0; out_ready SHALL be ignored when out_valid=0.
- REQ-023: count SHALL change by exactly +1 (push only), -1 (pop only) or 0 per edge.

Reset
- REQ-024: When RESET=1 at an edge, write pointer, read pointer and count SHALL be 0 after that edge; push and pop on that edge are discarded.
- REQ-025: During and after reset: out_valid=0, out_data=16'h0000, in_ready=1, count=0.
- REQ-026: Storage array SHALL NOT require reset; stale contents SHALL never appear on out_data.
- REQ-027: Reset asserted mid-operation (any count) SHALL flush all entries; the first push after release returns normal behaviour.

Verification
- REQ-028: Reset then single word: SWAP=1, push 16'h1234, out_ready=0 -> next cycle out_valid=1, out_data=16'h3412, count=1.
- REQ-029: Fill to full: DEPTH=4, push 16'hA0B1, 16'hC2D3, 16'hE4F5, 16'h0617, out_ready=0 -> count=4, in_ready=0; a fifth push of 16'hFFFF is not accepted; drain yields 16'hB1A0, 16'hD3C2, 16'hF5E4, 16'h1706, then count=0, out_data=16'h0000.
- REQ-030: Full with concurrent push+pop: count=4, in_valid=1, out_ready=1 for one edge -> one pop only, count=3, in_ready=1 next cycle.
- REQ-031: Streaming with wrap: in_valid=1 and out_ready=1 continuously for 10 words 16'h0001..16'h000A -> one word per cycle after the first, outputs 16'h0100..16'h0A00 in order, count stays at 1, pointers wrap at least twice.
- REQ-032: Reset mid-operation: count=3, RESET=1 for one edge with in_valid=1 -> count=0, out_valid=0, out_data=16'h0000, pushed word discarded.
- REQ-033: SWAP=0 build: push 16'h1234 -> out_data=16'h1234.

Source files
------------

// File: rtl/slice_swap_fifo.sv
// -----------------------------------------------------------------------------
// slice_swap_fifo
//
// Synchronous FIFO of DEPTH 16-bit entries. Each word is stored either
// byte-swapped (SWAP=1) or unchanged (SWAP=0). The head of the queue is
// presented on out_data, or zero when the queue is empty.
//
// Handshake flags are decoded only from the registered occupancy. As a
// result, a full queue refuses a push even if a pop happens on the same
// edge. There is no bypass: a word becomes visible on the cycle after the
// edge that pushed it.
//
// Parameters
//   DEPTH     number of entries; a power of two from 2 to 16 (default 4)
//   SWAP      1 = store {in_data[7:0], in_data[15:8]}, 0 = store as-is
//
// Ports
//   CLK       clock; all state updates on the rising edge
//   RESET     synchronous, active-high; flushes pointers and count
//   in_data   upstream word
//   in_valid  upstream word valid
//   in_ready  block can accept a word this cycle (count < DEPTH)
//   out_data  head-of-queue word in stored form; 16'h0000 when empty
//   out_valid out_data valid (count != 0)
//   out_ready downstream consumes the head this cycle
//   count     current occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module slice_swap_fifo #(
    parameter int DEPTH = 4,
    parameter int SWAP  = 1
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic [15:0]                in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [15:0]                out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Catch unsupported sizes at elaboration. The pointer wrap below
    // relies on DEPTH being an exact power of two.
    generate
        if ((DEPTH < 2) || (DEPTH > 16) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
            $error("slice_swap_fifo: DEPTH must be a power of two in 2..16");
        end
        if ((SWAP != 0) && (SWAP != 1)) begin : g_bad_swap
            $error("slice_swap_fifo: SWAP must be 0 or 1");
        end
    endgenerate

    // Convert an incoming word to the form it is stored in.
    function automatic logic [15:0] store_form(input logic [15:0] w);
        if (SWAP != 0) begin
            return {w[7:0], w[15:8]};
        end
        return w;
    endfunction

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [15:0]      mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;

    logic push;
    logic pop;

    // -------------------------------------------------------------------------
    // Flags: decoded only from registered count
    // -------------------------------------------------------------------------
    assign in_ready  = (count_q < CNT_W'(DEPTH));
    assign out_valid = (count_q != '0);
    assign count     = count_q;

    // The zero mask ensures that stale or never-written storage cannot
    // leak out while the queue is empty.
    assign out_data  = out_valid ? mem_q[rd_ptr_q] : 16'h0000;

    assign push = in_valid  & in_ready;
    assign pop  = out_valid & out_ready;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        // Pointers are exactly log2(DEPTH) bits wide, so incrementing
        // them wraps from DEPTH-1 to 0 naturally.
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // -------------------------------------------------------------------------
    // Control registers (reset)
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RESET) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // -------------------------------------------------------------------------
    // Storage (no reset)
    // -------------------------------------------------------------------------
    // A write during reset is harmless: count is forced to zero, so the
    // entry is never exposed and is overwritten by later pushes.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem_q[wr_ptr_q] <= store_form(in_data);
        end
    end

endmodule
